seq_divider: RTL and testbench
==============================

# seq_divider

Multi-cycle restoring divider: the inverse of the team's combinational `product = var1*var2` datapath. It takes a product-width dividend and an operand-width divisor and recovers `quotient` and `remainder` one bit per clock. It sits beside the multiplier in the arithmetic sandbox and is driven by a start/done handshake from a testbench or controller.

## Interface
- `DIVIDEND_W`, default 16: dividend and quotient width, equal to the multiplier product width.
- `DIVISOR_W`, default 8: divisor and remainder width, equal to the multiplier operand width.

- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: reset is synchronous and active-high.
- `start` input 1: request a division; sampled only when `busy`=0.
- `dividend` input DIVIDEND_W: unsigned dividend; captured on the accepting edge.
- `divisor` input DIVISOR_W: unsigned divisor; captured on the accepting edge.
- `busy` output 1: high while an operation is in flight (state RUN).
- `done` output 1: one-cycle pulse when results become valid.
- `quotient` output DIVIDEND_W: unsigned quotient; held until the next accepted start.
- `remainder` output DIVISOR_W: unsigned remainder; held until the next accepted start.
- `div_by_zero` output 1: set with `done` when the captured divisor was 0; held with the results.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE -> RUN on `start`=1 with a nonzero divisor.
  - IDLE -> DONE on `start`=1 with `divisor`=0.
  - RUN -> DONE after DIVIDEND_W iterations.
  - DONE -> IDLE unconditionally, or DONE -> RUN/DONE if `start`=1 that cycle (back-to-back accepted).
- On accept:
  - Latch the divisor.
  - Load the shift register with the dividend.
  - Clear the partial remainder (DIVISOR_W+1 bits) and the iteration counter.
  - Clear `div_by_zero` unless the divisor is 0.
- Each RUN cycle, restoring step:
  - rem' = {rem[DIVISOR_W-1:0], q_msb}; shift q left.
  - If rem' >= divisor: rem = rem' - divisor and q LSB = 1; else rem = rem' and q LSB = 0.
  - Increment the counter; after the step with count = DIVIDEND_W-1, go to DONE.
- Arithmetic:
  - Comparison and subtraction are DIVISOR_W+1 bits wide, unsigned.
  - The final remainder always fits in DIVISOR_W bits.
  - No overflow is possible because the quotient width equals the dividend width.
- Divide by zero:
  - Skip RUN.
  - `quotient` = all ones, `remainder` = dividend[DIVISOR_W-1:0], `div_by_zero` = 1.
- `quotient` and `remainder` outputs update only on entry to DONE. Intermediate shift values are never visible on the outputs.
- `start` while `busy`=1 is ignored: no restart, no queuing, operands not captured.
- Changes to `dividend`/`divisor` after the accepting edge have no effect.

## Timing
- Reset values: state IDLE; `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `div_by_zero`=0; counter 0.
- Nonzero divisor, start accepted at edge k:
  - `busy`=1 from edge k through edge k+DIVIDEND_W.
  - Results valid and `done`=1 for exactly the cycle following edge k+DIVIDEND_W (16 cycles of latency at the default width).
  - `busy`=0 in that cycle.
- Zero divisor, accepted at edge k: `done`=1 in the cycle after edge k (latency 1); `busy` never rises.
- `done` is never high for two consecutive cycles unless two operations complete back-to-back, which is possible only for consecutive divide-by-zero requests.
- `start`=1 during the `done` cycle is accepted at that edge; throughput is one operation per DIVIDEND_W+1 cycles.
- `rst` mid-operation: the next edge forces the reset state, the in-flight result is discarded, and `done` does not pulse. `rst` has priority over `start` on the same edge.

## Test plan
- Reset, then `dividend`=330, `divisor`=33, `start` pulse -> 16 cycles later `done`=1, `quotient`=10, `remainder`=0, `div_by_zero`=0; `busy` high for exactly 16 cycles.
- `dividend`=1000, `divisor`=33 -> `quotient`=30, `remainder`=10. Then `dividend`=7, `divisor`=200 -> `quotient`=0, `remainder`=7.
- Extremes: 65535/1 -> `quotient`=65535, `remainder`=0. 65535/255 -> `quotient`=257, `remainder`=0. 0/9 -> `quotient`=0, `remainder`=0.
- `dividend`=5, `divisor`=0 -> `done` one cycle after start, `quotient`=16'hFFFF, `remainder`=5, `div_by_zero`=1. A following 132/4 -> `quotient`=33, `remainder`=0, `div_by_zero`=0.
- Pulse `start` with 50/7 mid-RUN of 330/33 and toggle the operands -> the result is still 10 r 0 at the original time; no second `done`.
- Assert `rst` at iteration 8 of 1000/33 -> all outputs 0 next cycle, no `done` pulse. A fresh 100/9 afterwards -> `quotient`=11, `remainder`=1.

Source files
------------

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
//
// Multi-cycle restoring divider that undoes the team's combinational
// product = var1 * var2 datapath. It takes a product-width dividend and an
// operand-width divisor, then produces one quotient bit per clock.
// A start/done handshake drives each operation.
//
// Parameters
//   DIVIDEND_W  dividend / quotient width (multiplier product width)
//   DIVISOR_W   divisor / remainder width (multiplier operand width)
//
// Ports
//   clk          single clock; all state updates on the rising edge
//   rst          synchronous, active-high reset
//   start        request a division; sampled only while busy = 0
//   dividend     unsigned dividend, captured on the accepting edge
//   divisor      unsigned divisor, captured on the accepting edge
//   busy         high while an operation is in flight (state RUN)
//   done         one-cycle pulse while the results are newly valid
//   quotient     unsigned quotient, held until the next accepted start
//   remainder    unsigned remainder, held until the next accepted start
//   div_by_zero  set with done when the captured divisor was zero
//
// Latency: a nonzero divisor takes DIVIDEND_W cycles in RUN, then one cycle
// in DONE. A zero divisor skips RUN and reaches DONE on the accepting edge.
// -----------------------------------------------------------------------------
module seq_divider #(
    parameter int DIVIDEND_W = 16,
    parameter int DIVISOR_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIVIDEND_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_next;

    // Working registers. They never drive the outputs directly, so the
    // intermediate shift values stay invisible to the outside.
    logic [DIVIDEND_W-1:0] q_r;      // dividend in, quotient bits out
    logic [DIVISOR_W:0]    rem_r;    // partial remainder, one guard bit
    logic [DIVISOR_W-1:0]  div_r;    // latched divisor
    logic [CNT_W-1:0]      count;

    logic accept;
    logic zero_div;
    logic last_step;

    // Restoring step signals
    logic [DIVISOR_W:0]    rem_shift;
    logic [DIVISOR_W:0]    div_ext;
    logic                  take;
    logic [DIVISOR_W:0]    rem_step;
    logic [DIVIDEND_W-1:0] q_step;

    // start is honoured in IDLE and in the DONE cycle. That gives
    // back-to-back throughput of one operation per DIVIDEND_W+1 cycles.
    assign accept    = start && (state != RUN);
    assign zero_div  = (divisor == '0);
    assign last_step = (count == LAST_STEP);

    // Shift the next dividend bit into the partial remainder. Then subtract
    // the divisor if it fits. The compare and subtract are DIVISOR_W+1 bits
    // wide. The result is always < divisor, so it fits back in DIVISOR_W bits
    // plus the guard bit.
    assign rem_shift = {rem_r[DIVISOR_W-1:0], q_r[DIVIDEND_W-1]};
    assign div_ext   = {1'b0, div_r};
    assign take      = (rem_shift >= div_ext);
    assign rem_step  = take ? (rem_shift - div_ext) : rem_shift;
    assign q_step    = {q_r[DIVIDEND_W-2:0], take};

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and handshake outputs
    // -------------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;

        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = zero_div ? DONE : RUN;
                end
            end

            RUN: begin
                busy = 1'b1;
                if (last_step) begin
                    state_next = DONE;
                end
            end

            DONE: begin
                done = 1'b1;
                if (start) begin
                    state_next = zero_div ? DONE : RUN;
                end else begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath and result registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r         <= '0;
            rem_r       <= '0;
            div_r       <= '0;
            count       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            div_r <= divisor;
            q_r   <= dividend;
            rem_r <= '0;
            count <= '0;
            if (zero_div) begin
                // Division by zero goes straight to DONE with the
                // conventional saturated result.
                quotient    <= '1;
                remainder   <= dividend[DIVISOR_W-1:0];
                div_by_zero <= 1'b1;
            end else begin
                // The previous results stay visible during the new run.
                // Only the error flag is cleared here.
                div_by_zero <= 1'b0;
            end
        end else if (state == RUN) begin
            q_r   <= q_step;
            rem_r <= rem_step;
            count <= count + 1'b1;
            if (last_step) begin
                // The results are published only when the FSM enters DONE.
                quotient  <= q_step;
                remainder <= rem_step[DIVISOR_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
//
// Directed testbench for seq_divider at its default widths (16 / 8).
// Inputs change 1 ns after a rising edge, and outputs are sampled at that
// same point. Every expected value below was computed by hand.
// -----------------------------------------------------------------------------
module tb_seq_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;

    int checks = 0;
    int errors = 0;

    seq_divider #(
        .DIVIDEND_W(16),
        .DIVISOR_W (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1 ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue a one-cycle start, then wait (bounded) for done.
    // lat counts edges after the accepting edge until done is seen.
    // busy_cyc counts the samples in which busy was high.
    task automatic run_op(input logic [15:0] dd, input logic [7:0] ds,
                          output int lat, output int busy_cyc,
                          output bit timeout);
        dividend = dd;
        divisor  = ds;
        start    = 1'b1;
        step();
        start    = 1'b0;
        lat      = 0;
        busy_cyc = 0;
        while (!done && lat < 40) begin
            if (busy) busy_cyc++;
            step();
            lat++;
        end
        timeout = !done;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        step();
        step();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_handshake: busy=%b done=%b, required 0 0", busy, done);
        end
        checks++;
        if (quotient !== 16'd0 || remainder !== 8'd0 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_results: q=%0d r=%0d dbz=%b, required 0 0 0",
                     quotient, remainder, div_by_zero);
        end
        rst = 1'b0;
        step();
    endtask

    // -------------------------------------------------------------------------
    task automatic test_basic();
        int lat, bc;
        bit to;
        run_op(16'd330, 8'd33, lat, bc, to);
        checks++;
        if (to || lat != 16) begin
            errors++;
            $display("FAIL basic_latency: %0d edges (timeout=%0b), required 16", lat, to);
        end
        checks++;
        if (bc != 16 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy: busy cycles=%0d busy_in_done=%b, required 16 0", bc, busy);
        end
        checks++;
        if (quotient !== 16'd10 || remainder !== 8'd0 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: q=%0d r=%0d dbz=%b, required 10 0 0",
                     quotient, remainder, div_by_zero);
        end
        step();
        checks++;
        if (done !== 1'b0 || quotient !== 16'd10) begin
            errors++;
            $display("FAIL basic_pulse: done=%b q=%0d after done cycle, required 0 10",
                     done, quotient);
        end
    endtask

    // -------------------------------------------------------------------------
    typedef struct packed {
        logic [15:0] dd;
        logic [7:0]  ds;
        logic [15:0] q;
        logic [7:0]  r;
    } vec_t;

    task automatic test_vectors();
        vec_t vecs [8];
        int lat, bc;
        bit to;
        vecs = '{
            '{16'd1000,  8'd33,  16'd30,    8'd10},
            '{16'd7,     8'd200, 16'd0,     8'd7},
            '{16'd65535, 8'd1,   16'd65535, 8'd0},
            '{16'd65535, 8'd255, 16'd257,   8'd0},
            '{16'd0,     8'd9,   16'd0,     8'd0},
            '{16'd65535, 8'd2,   16'd32767, 8'd1},
            '{16'd100,   8'd7,   16'd14,    8'd2},
            '{16'd255,   8'd16,  16'd15,    8'd15}
        };
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].dd, vecs[i].ds, lat, bc, to);
            checks++;
            if (to || lat != 16 || quotient !== vecs[i].q || remainder !== vecs[i].r
                || div_by_zero !== 1'b0) begin
                errors++;
                $display("FAIL vec_%0d %0d/%0d: lat=%0d q=%0d r=%0d dbz=%b, required lat=16 q=%0d r=%0d dbz=0",
                         i, vecs[i].dd, vecs[i].ds, lat, quotient, remainder, div_by_zero,
                         vecs[i].q, vecs[i].r);
            end
            step();
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_div_by_zero();
        int lat, bc;
        bit to;
        run_op(16'd5, 8'd0, lat, bc, to);
        checks++;
        if (to || lat != 0 || bc != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL dbz_timing: lat=%0d busy_cycles=%0d busy=%b, required 0 0 0",
                     lat, bc, busy);
        end
        checks++;
        if (quotient !== 16'hFFFF || remainder !== 8'd5 || div_by_zero !== 1'b1) begin
            errors++;
            $display("FAIL dbz_result: q=%h r=%0d dbz=%b, required ffff 5 1",
                     quotient, remainder, div_by_zero);
        end
        step();
        step();
        checks++;
        if (done !== 1'b0 || div_by_zero !== 1'b1 || quotient !== 16'hFFFF) begin
            errors++;
            $display("FAIL dbz_hold: done=%b dbz=%b q=%h, required 0 1 ffff",
                     done, div_by_zero, quotient);
        end
        run_op(16'd132, 8'd4, lat, bc, to);
        checks++;
        if (to || lat != 16 || quotient !== 16'd33 || remainder !== 8'd0 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL dbz_recover: lat=%0d q=%0d r=%0d dbz=%b, required 16 33 0 0",
                     lat, quotient, remainder, div_by_zero);
        end
        step();
    endtask

    // -------------------------------------------------------------------------
    task automatic test_back_to_back();
        int lat, bc;
        bit to;
        run_op(16'd100, 8'd7, lat, bc, to);
        // Still in the done cycle: a divide-by-zero start is accepted now.
        dividend = 16'd20;
        divisor  = 8'd0;
        start    = 1'b1;
        step();
        checks++;
        if (done !== 1'b1 || quotient !== 16'hFFFF || remainder !== 8'd20 || div_by_zero !== 1'b1) begin
            errors++;
            $display("FAIL b2b_dbz: done=%b q=%h r=%0d dbz=%b, required 1 ffff 20 1",
                     done, quotient, remainder, div_by_zero);
        end
        // Second done cycle in a row: accept a normal division.
        dividend = 16'd300;
        divisor  = 8'd10;
        step();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept: busy=%b done=%b dbz=%b, required 1 0 0",
                     busy, done, div_by_zero);
        end
        lat = 0;
        while (!done && lat < 40) begin
            step();
            lat++;
        end
        checks++;
        if (lat != 16 || quotient !== 16'd30 || remainder !== 8'd0) begin
            errors++;
            $display("FAIL b2b_result: lat=%0d q=%0d r=%0d, required 16 30 0",
                     lat, quotient, remainder);
        end
        step();
    endtask

    // -------------------------------------------------------------------------
    task automatic test_ignore_start();
        int lat;
        int extra_done;
        dividend = 16'd330;
        divisor  = 8'd33;
        start    = 1'b1;
        step();
        start = 1'b0;
        lat   = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            lat++;
        end
        // Mid-RUN start with other operands must be ignored.
        dividend = 16'd50;
        divisor  = 8'd7;
        start    = 1'b1;
        step();
        lat++;
        start    = 1'b0;
        dividend = 16'h1234;
        divisor  = 8'd0;
        while (!done && lat < 40) begin
            step();
            lat++;
        end
        checks++;
        if (lat != 16 || quotient !== 16'd10 || remainder !== 8'd0 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL ignore_result: lat=%0d q=%0d r=%0d dbz=%b, required 16 10 0 0",
                     lat, quotient, remainder, div_by_zero);
        end
        extra_done = 0;
        for (int i = 0; i < 24; i++) begin
            step();
            if (done || busy) extra_done++;
        end
        checks++;
        if (extra_done != 0) begin
            errors++;
            $display("FAIL ignore_no_second: %0d cycles with busy/done after result, required 0",
                     extra_done);
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset_mid();
        int lat, bc;
        int seen_done;
        bit to;
        dividend = 16'd1000;
        divisor  = 8'd33;
        start    = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 8; i++) step();
        // Assert rst together with start: rst must win.
        rst   = 1'b1;
        start = 1'b1;
        step();
        rst   = 1'b0;
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || quotient !== 16'd0 || remainder !== 8'd0
            || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_state: busy=%b done=%b q=%0d r=%0d dbz=%b, required all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        seen_done = 0;
        for (int i = 0; i < 20; i++) begin
            if (done || busy) seen_done++;
            step();
        end
        checks++;
        if (seen_done != 0) begin
            errors++;
            $display("FAIL rst_mid_no_done: %0d cycles with busy/done after reset, required 0",
                     seen_done);
        end
        run_op(16'd100, 8'd9, lat, bc, to);
        checks++;
        if (to || lat != 16 || quotient !== 16'd11 || remainder !== 8'd1) begin
            errors++;
            $display("FAIL rst_mid_fresh: lat=%0d q=%0d r=%0d, required 16 11 1",
                     lat, quotient, remainder);
        end
        step();
    endtask

    // -------------------------------------------------------------------------
    initial begin
        test_reset();
        test_basic();
        test_vectors();
        test_div_by_zero();
        test_back_to_back();
        test_ignore_start();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Overall guard in case a wait somewhere is never bounded as intended.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
